// File: rtl/bcd_fenpin_pkg.sv
// Shared types and constants for the BCD divide-by-M counter.
package bcd_fenpin_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // True when a BCD digit is within 0..dmax.
    function automatic logic bcd_in_range(input bcd_digit_t d, input bcd_digit_t dmax);
        return (d <= dmax);
    endfunction

endpackage

// File: rtl/bcd_fenpin_counter_if.sv
// Bundle of the counter's control and status signals, used by the bench to drive the block.
interface bcd_fenpin_counter_if #(
    parameter int DIGITS = 2
) (
    input logic clk
);

    logic                  cin;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  dir;
    logic [4*DIGITS-1:0]   count;
    logic                  tc;
    logic                  x;

    modport master (
        input  clk,
        output cin, load, load_val, dir,
        input  count, tc, x
    );

    modport slave (
        input  clk,
        input  cin, load, load_val, dir,
        output count, tc, x
    );

endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the counter chain: wraps at DMAX (up) or 0 (down) and forwards carry/borrow.
module bcd_digit_cell
    import bcd_fenpin_pkg::*;
#(
    parameter int DMAX = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  bcd_digit_t load_val,
    input  logic       dir,
    input  logic       cin,
    output logic       cout,
    output bcd_digit_t digit
);

    localparam bcd_digit_t DMAX_D = bcd_digit_t'(DMAX);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;
    logic       at_term;

    assign at_term = dir ? (digit_q == 4'd0) : (digit_q == DMAX_D);
    assign cout    = cin & at_term;
    assign digit   = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (clear) begin
            digit_d = 4'd0;
        end else if (load) begin
            // Out-of-range digits load as zero rather than an illegal code.
            digit_d = bcd_in_range(load_val, DMAX_D) ? load_val : 4'd0;
        end else if (cin) begin
            if (dir) begin
                digit_d = at_term ? DMAX_D : (digit_q - 4'd1);
            end else begin
                digit_d = at_term ? 4'd0 : (digit_q + 4'd1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/bcd_fenpin_counter.sv
// BCD modulo-(TOP_MAX+1)*10^(DIGITS-1) counter with terminal-count pulse and divided toggle x.
// Define BCD_FENPIN_UPDOWN_EN to enable down counting via dir; otherwise dir is ignored.
module bcd_fenpin_counter
    import bcd_fenpin_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int TOP_MAX = 7
) (
    input  logic                clk,
    input  logic                Rst,
    input  logic                Cin,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                dir,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                x
);

    logic dir_eff;

`ifdef BCD_FENPIN_UPDOWN_EN
    assign dir_eff = dir;
`else
    logic unused_dir;
    assign dir_eff    = 1'b0;
    assign unused_dir = dir;
`endif

    // Per-digit carry wires live in their own generate scope so the ripple chain is not a single vector.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic cin_w;
        logic cout_w;

        if (i == 0) begin : g_first
            assign cin_w = Cin;
        end else begin : g_rest
            assign cin_w = g_digit[i-1].cout_w;
        end

        bcd_digit_cell #(
            .DMAX ((i == DIGITS-1) ? TOP_MAX : int'(BCD_MAX))
        ) u_cell (
            .clk      (clk),
            .rst      (Rst),
            .clear    (1'b0),
            .load     (load),
            .load_val (load_val[4*i +: 4]),
            .dir      (dir_eff),
            .cin      (cin_w),
            .cout     (cout_w),
            .digit    (count[4*i +: 4])
        );
    end

    logic tc_q, tc_d;
    logic x_q, x_d;

    // Carry out of the MS digit means Cin was sampled with the whole count at its terminal value.
    always_comb begin
        tc_d = g_digit[DIGITS-1].cout_w & ~load;
        x_d  = x_q ^ tc_d;
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            tc_q <= 1'b0;
            x_q  <= 1'b0;
        end else begin
            tc_q <= tc_d;
            x_q  <= x_d;
        end
    end

    assign tc = tc_q;
    assign x  = x_q;

endmodule
